byte_packer: RTL and testbench

BYTE_PACKER -- requirements
Module: byte_packer

---
 rtl/byte_packer_pkg.sv | 10 +
 rtl/byte_packer.sv | 103 ++++++++++
 tb/tb_byte_packer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_packer_pkg.sv
// Shared constants and types for the byte packer.
// Lane index type is sized for the default lane count.
package byte_packer_pkg;

  localparam int BYTE_W      = 8;
  localparam int N_BYTES_DEF = 4;

  typedef logic [$clog2(N_BYTES_DEF)-1:0] lane_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into N_BYTES-wide little-endian words.
// One byte per cycle, words complete on full lanes or packet end.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int N_BYTES = N_BYTES_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BYTE_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BYTE_W*N_BYTES-1:0]   out_data,
  output logic [N_BYTES-1:0]          out_keep,
  output logic                        out_last
);

  localparam int DW = BYTE_W * N_BYTES;
  localparam int CW = $clog2(N_BYTES);
  localparam logic [CW-1:0] LAST_LANE = CW'(N_BYTES - 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      acc_q, acc_d;
  logic [N_BYTES-1:0] kacc_q, kacc_d;
  logic [DW-1:0]      od_q, od_d;
  logic [N_BYTES-1:0] ok_q, ok_d;
  logic               ol_q, ol_d;
  logic               ov_q, ov_d;

  logic [DW-1:0]      acc_m;
  logic [N_BYTES-1:0] keep_m;
  logic               accept;
  logic               done;

  // Ready only from output side so upstream never sees a loop.
  assign in_ready = !ov_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign done     = accept && (cnt_q == LAST_LANE || in_last);

  always_comb begin
    acc_m  = acc_q;
    keep_m = kacc_q;
    acc_m[BYTE_W*int'(cnt_q) +: BYTE_W] = in_data;
    keep_m[cnt_q] = 1'b1;
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    kacc_d = kacc_q;
    od_d   = od_q;
    ok_d   = ok_q;
    ol_d   = ol_q;
    ov_d   = ov_q;
    if (done) begin
      od_d   = acc_m;
      ok_d   = keep_m;
      ol_d   = in_last;
      ov_d   = 1'b1;
      cnt_d  = '0;
      acc_d  = '0;
      kacc_d = '0;
    end else begin
      if (accept) begin
        cnt_d  = cnt_q + CW'(1);
        acc_d  = acc_m;
        kacc_d = keep_m;
      end
      if (ov_q && out_ready) begin
        ov_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      kacc_q <= '0;
      od_q   <= '0;
      ok_q   <= '0;
      ol_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      kacc_q <= kacc_d;
      od_q   <= od_d;
      ok_q   <= ok_d;
      ol_q   <= ol_d;
      ov_q   <= ov_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_keep  = ok_q;
  assign out_last  = ol_q;

endmodule

// File: tb/tb_byte_packer.sv
// Scoreboard bench for byte_packer (N_BYTES = 4).
// Expected words are queued on input accept, checked on output transfer.
module tb_byte_packer;
  import byte_packer_pkg::*;

  localparam int NB = 4;

  typedef struct packed {
    logic [8*NB-1:0] data;
    logic [NB-1:0]   keep;
    logic            last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [8*NB-1:0] out_data;
  logic [NB-1:0] out_keep;
  logic          out_last;

  int vectors = 0;
  int miscompares = 0;
  int stalls = 0;
  int words_out = 0;
  int words_exp = 0;
  bit rnd_bp = 0;

  word_t sb_q[$];
  logic [8*NB-1:0] m_acc = '0;
  logic [NB-1:0]   m_keep = '0;
  int              m_cnt = 0;

  byte_packer #(.N_BYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    word_t e;
    if (rst) begin
      sb_q.delete();
      m_acc  = '0;
      m_keep = '0;
      m_cnt  = 0;
    end else begin
      if (out_valid && out_ready) begin
        words_out++;
        if (sb_q.size() == 0) begin
          chk("unexpected_word", {31'd0, out_valid}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_data", 64'(out_data), 64'(e.data));
          chk("sb_keep", 64'(out_keep), 64'(e.keep));
          chk("sb_last", 64'(out_last), 64'(e.last));
        end
      end
      if (in_valid && in_ready) begin
        m_acc[8*m_cnt +: 8] = in_data;
        m_keep[m_cnt] = 1'b1;
        if (m_cnt == NB - 1 || in_last) begin
          e.data = m_acc;
          e.keep = m_keep;
          e.last = in_last;
          sb_q.push_back(e);
          words_exp++;
          m_acc  = '0;
          m_keep = '0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  a_stable: assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready |=>
      out_valid && $stable(out_data) &&
      $stable(out_keep) && $stable(out_last));

  a_ready: assert property (@(posedge clk)
    in_ready == (!out_valid || out_ready));

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit ok;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
      if (ok) break;
      stalls++;
      n++;
      if (n > 100) begin
        chk("in_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    logic [7:0] b;
    idle(3);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("init_data", 64'(out_data), 64'd0);
    chk("init_keep", 64'(out_keep), 64'd0);
    chk("init_last", 64'(out_last), 64'd0);
    @(posedge clk);
    #1;

    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    @(negedge clk);
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_data", 64'(out_data), 64'h44332211);
    chk("full_keep", 64'(out_keep), 64'hF);
    chk("full_last", 64'(out_last), 64'd0);
    @(posedge clk);
    #1;

    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    @(negedge clk);
    chk("short_data", 64'(out_data), 64'h0000BBAA);
    chk("short_keep", 64'(out_keep), 64'h3);
    chk("short_last", 64'(out_last), 64'd1);
    @(posedge clk);
    #1;

    send_byte(8'h5A, 1);
    @(negedge clk);
    chk("one_data", 64'(out_data), 64'h0000005A);
    chk("one_keep", 64'(out_keep), 64'h1);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    send_byte(8'hC1, 0);
    send_byte(8'hC2, 0);
    send_byte(8'hC3, 0);
    send_byte(8'hC4, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", 64'(out_data), 64'hC4C3C2C1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    stalls = 0;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
    @(negedge clk);
    chk("b2b_data2", 64'(out_data), 64'h08070605);
    chk("b2b_stalls", 64'(stalls), 64'd0);
    @(posedge clk);
    #1;

    send_byte(8'hE1, 0);
    send_byte(8'hE2, 0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    idle(2);
    rst = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_keep", 64'(out_keep), 64'd0);
    @(posedge clk);
    #1;
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    @(negedge clk);
    chk("post_rst_data", 64'(out_data), 64'h88776655);
    chk("post_rst_keep", 64'(out_keep), 64'hF);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h90 + 8'(i), 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pend_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    rnd_bp = 1;
    for (int i = 0; i < 200; i++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b, ($urandom_range(0, 5) == 0));
    end
    rnd_bp = 0;
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

endmodule
